memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/memory_arbiter.sv | 114 +++++++++++
 tb/tb_memory_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encodings and port ids.
package memory_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  localparam logic PortIf = 1'b0;
  localparam logic PortD  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter2
  import memory_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = PortIf;
    case (req)
      2'b01:   grant = PortIf;
      2'b10:   grant = PortD;
      2'b11:   grant = ~last_grant;
      default: grant = PortIf;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-ported ram.
// Every transaction is IDLE -> ACCESS -> DONE; the ram sees only latched request state.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned SIZE_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] ram_address,
  output logic [31:0] ram_input_data,
  output logic        ram_should_write,
  input  logic [31:0] ram_output_data,
  output logic        busy
);

  // Out-of-range addresses are forwarded untouched, so the depth is only sanity-checked here.
  if (SIZE_WORDS < 1) begin : gen_bad_size
    $error("memory_arbiter: SIZE_WORDS must be at least 1");
  end

  arb_state_e  state_q;
  logic        grant_q;
  logic        last_grant_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        if_done_q;
  logic        d_done_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        grant;

  rr_arbiter2 u_rr_arbiter2 (
    .req        ({d_req, if_req}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= PortIf;
      last_grant_q <= PortD;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req || d_req) begin
            grant_q      <= grant;
            last_grant_q <= grant;
            addr_q       <= (grant == PortD) ? d_addr : if_addr;
            wdata_q      <= (grant == PortD) ? d_wdata : '0;
            we_q         <= (grant == PortD) && d_we;
            state_q      <= StAccess;
          end
        end
        StAccess: begin
          // The ram read is combinational, so its data is valid at the edge ending ACCESS.
          if (grant_q == PortD) begin
            d_done_q <= 1'b1;
            if (!we_q) d_rdata_q <= ram_output_data;
          end else begin
            if_done_q  <= 1'b1;
            if_rdata_q <= ram_output_data;
          end
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ram_address      = '0;
    ram_input_data   = '0;
    ram_should_write = 1'b0;
    if (state_q == StAccess) begin
      ram_address      = addr_q;
      ram_input_data   = wdata_q;
      ram_should_write = we_q;
    end
  end

  assign if_done  = if_done_q;
  assign d_done   = d_done_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a 32-word ram model that writes on the falling edge.
module tb_memory_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [31:0] ram_address;
  logic [31:0] ram_input_data;
  logic        ram_should_write;
  logic [31:0] ram_output_data;
  logic        busy;

  memory_arbiter #(
    .SIZE_WORDS (32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_done          (if_done),
    .if_rdata         (if_rdata),
    .d_req            (d_req),
    .d_we             (d_we),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_done           (d_done),
    .d_rdata          (d_rdata),
    .ram_address      (ram_address),
    .ram_input_data   (ram_input_data),
    .ram_should_write (ram_should_write),
    .ram_output_data  (ram_output_data),
    .busy             (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [32];
  logic [31:0] widx;
  assign widx = ram_address >> 2;
  assign ram_output_data = (widx < 32) ? mem[widx[4:0]] : 32'h0;

  always @(negedge clock) begin
    if (ram_should_write && (widx < 32)) mem[widx[4:0]] <= ram_input_data;
  end

  int n_if_done = 0;
  int n_d_done  = 0;
  int n_both    = 0;
  int n_wr      = 0;

  always @(negedge clock) begin
    if (if_done) n_if_done <= n_if_done + 1;
    if (d_done) n_d_done <= n_d_done + 1;
    if (if_done && d_done) n_both <= n_both + 1;
    if (ram_should_write) n_wr <= n_wr + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    tick();
    check("d_acc_addr", ram_address, addr);
    check("d_acc_we", 32'(ram_should_write), 32'(we));
    check("d_acc_wdata", ram_input_data, wdata);
    tick();
    check("d_done", 32'(d_done), 32'd1);
    check("d_done_if_low", 32'(if_done), 32'd0);
    check("d_rdata", d_rdata, exp_rdata);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("d_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic if_txn(input logic [31:0] addr, input logic [31:0] exp_rdata);
    if_req = 1'b1; if_addr = addr;
    tick();
    check("if_acc_addr", ram_address, addr);
    check("if_acc_we", 32'(ram_should_write), 32'd0);
    check("if_acc_busy", 32'(busy), 32'd1);
    tick();
    check("if_done", 32'(if_done), 32'd1);
    check("if_done_d_low", 32'(d_done), 32'd0);
    check("if_rdata", if_rdata, exp_rdata);
    if_req = 1'b0;
    tick();
    check("if_idle_addr", ram_address, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_wr;
    int base_if;
    int base_d;
    int base_both;
    int k;
    logic [31:0] seq [4];

    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_d_done", 32'(d_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_ram_addr", ram_address, 32'h0);
    check("rst_ram_wdata", ram_input_data, 32'h0);
    check("rst_ram_we", 32'(ram_should_write), 32'd0);
    reset = 1'b0;

    // Preload word 2 through the data port, then fetch it back.
    d_txn(1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0);
    base_wr = n_wr;
    if_txn(32'h8, 32'hDEAD_BEEF);
    check("if_never_writes", 32'(n_wr - base_wr), 32'd0);

    // Data write then read of word 1; the write leaves d_rdata alone.
    base_wr = n_wr;
    d_txn(1'b1, 32'h4, 32'h1234_5678, 32'h0);
    d_txn(1'b0, 32'h4, 32'h0, 32'h1234_5678);
    check("wr_rd_one_write", 32'(n_wr - base_wr), 32'd1);
    check("mem_word1", mem[1], 32'h1234_5678);

    // Tie after reset: fetch first, data three cycles later.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base_both = n_both;
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4; d_wdata = '0;
    tick();
    check("tie_first_addr", ram_address, 32'h8);
    tick();
    check("tie_if_done", 32'(if_done), 32'd1);
    check("tie_d_not_done", 32'(d_done), 32'd0);
    if_req = 1'b0;
    tick();
    check("tie_done_gap", 32'(if_done | d_done), 32'd0);
    tick();
    check("tie_second_addr", ram_address, 32'h4);
    tick();
    check("tie_d_done", 32'(d_done), 32'd1);
    check("tie_if_quiet", 32'(if_done), 32'd0);
    check("tie_d_rdata", d_rdata, 32'h1234_5678);
    check("tie_if_rdata", if_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();
    check("tie_no_both", 32'(n_both - base_both), 32'd0);

    // Continuous dual requests for 12 cycles: IF, D, IF, D.
    base_if = n_if_done; base_d = n_d_done; base_both = n_both;
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ram_address != 32'h0) begin
        if (k < 4) seq[k] = ram_address;
        k++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("cont_accesses", 32'(k), 32'd4);
    check("cont_grant0", seq[0], 32'h8);
    check("cont_grant1", seq[1], 32'h4);
    check("cont_grant2", seq[2], 32'h8);
    check("cont_grant3", seq[3], 32'h4);
    tick();
    check("cont_if_dones", 32'(n_if_done - base_if), 32'd2);
    check("cont_d_dones", 32'(n_d_done - base_d), 32'd2);
    check("cont_no_both", 32'(n_both - base_both), 32'd0);

    // Out-of-range, misaligned fetch dropped right after grant: forwarded as is, still completes.
    if_req = 1'b1; if_addr = 32'h0001_0003;
    tick();
    check("oor_addr", ram_address, 32'h0001_0003);
    if_req = 1'b0;
    tick();
    check("oor_if_done", 32'(if_done), 32'd1);
    check("oor_if_rdata", if_rdata, 32'h0);
    tick();
    d_txn(1'b0, 32'h5, 32'h0, 32'h1234_5678);

    // Reset during a write ACCESS: the write lands, done never does.
    base_d = n_d_done;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'hA5A5_A5A5;
    tick();
    check("rw_acc_we", 32'(ram_should_write), 32'd1);
    reset = 1'b1;
    tick();
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_no_done", 32'(d_done), 32'd0);
    check("rw_we_low", 32'(ram_should_write), 32'd0);
    check("rw_mem_word3", mem[3], 32'hA5A5_A5A5);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
    check("rw_d_done_count", 32'(n_d_done - base_d), 32'd0);

    // A request held across reset deassertion is granted on the first IDLE cycle.
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h8;
    tick();
    reset = 1'b0;
    tick();
    check("held_addr", ram_address, 32'h8);
    if_req = 1'b0;
    tick();
    check("held_if_done", 32'(if_done), 32'd1);
    check("held_if_rdata", if_rdata, 32'hDEAD_BEEF);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
